// File: rtl/ysyx_lsu_mem_responder_pkg.sv
// Shared encodings for the LSU memory responder: strobe sizes, FSM states, default base.
package ysyx_lsu_mem_responder_pkg;

  localparam logic [7:0]  YSYX_STRB_B   = 8'h01;
  localparam logic [7:0]  YSYX_STRB_H   = 8'h03;
  localparam logic [7:0]  YSYX_STRB_W   = 8'h0f;

  localparam logic [31:0] YSYX_MEM_BASE = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    TURN    = 2'd3
  } state_t;

endpackage

// File: rtl/ysyx_lsu_mem_responder_sram_1rw.sv
// Word-organised data array with byte write enables; contents are never reset.
module ysyx_lsu_mem_responder_sram_1rw #(
  parameter int unsigned WORDS  = 1024,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 10,
  parameter int unsigned BYTES  = 4
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BYTES-1:0]  wr_be
);

  logic [DATA_W-1:0] mem [WORDS];

  // Read port feeds the responder's output register.
  assign rd_data = mem[rd_idx];

  // Synchronous byte-masked write.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/ysyx_lsu_mem_responder.sv
// LSU-side memory responder: one access at a time, fixed latency, fault reporting.
module ysyx_lsu_mem_responder
  import ysyx_lsu_mem_responder_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] MEM_BASE  = ADDR_W'(YSYX_MEM_BASE),
  parameter int unsigned       MEM_WORDS = 1024,
  parameter int unsigned       RD_LAT    = 2,
  parameter int unsigned       WR_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  input  logic [7:0]        lsu_rstrb,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rvalid,
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic              lsu_awvalid,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wstrb,
  input  logic              lsu_wvalid,
  output logic              lsu_wready,
  output logic              access_fault
);

  localparam int unsigned       BYTES     = DATA_W / 8;
  localparam int unsigned       IDX_W     = $clog2(MEM_WORDS);
  localparam int unsigned       MAX_LAT   = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int unsigned       CNT_W     = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_WORDS * 4);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        strb_q;

  logic              wr_req;
  logic              rd_req;
  logic              rd_fire;
  logic              wr_fire;
  logic              cur_fault;
  logic              mem_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] rel_addr;
  logic [7:0]        sel_strb;
  logic [1:0]        off;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] rd_mask;
  logic [DATA_W-1:0] wr_word;
  logic [BYTES-1:0]  wr_be;

  // Address decode, fault checks, lane alignment and one-cycle-early response strobes.
  // In IDLE the live request is decoded so a latency of 1 can still answer from a register.
  always_comb begin
    wr_req   = lsu_awvalid & lsu_wvalid;
    rd_req   = lsu_arvalid & ~wr_req;
    sel_addr = addr_q;
    sel_strb = strb_q;
    if (state == IDLE) begin
      sel_addr = wr_req ? lsu_awaddr : lsu_araddr;
      sel_strb = wr_req ? lsu_wstrb  : lsu_rstrb;
    end

    // Wrapping subtraction folds the below-base case into the upper-bound compare.
    rel_addr  = sel_addr - MEM_BASE;
    off       = sel_addr[1:0];
    idx       = rel_addr[IDX_W+1:2];
    cur_fault = (rel_addr >= MEM_BYTES)
              | ~((sel_strb == YSYX_STRB_B)
                | ((sel_strb == YSYX_STRB_H) && (off != 2'd3))
                | ((sel_strb == YSYX_STRB_W) && (off == 2'd0)));

    rd_shift = rd_word >> {off, 3'b000};
    rd_mask  = '1;
    if (sel_strb == YSYX_STRB_B)      rd_mask = DATA_W'(8'hff);
    else if (sel_strb == YSYX_STRB_H) rd_mask = DATA_W'(16'hffff);

    wr_word = wdata_q << {off, 3'b000};
    wr_be   = BYTES'(strb_q) << off;

    rd_fire = ((state == IDLE) && rd_req && (RD_LAT == 1))
            || ((state == RD_WAIT) && (cnt == CNT_W'(1)));
    wr_fire = ((state == IDLE) && wr_req && (WR_LAT == 1))
            || ((state == WR_WAIT) && (cnt == CNT_W'(1)));

    // Commit on the edge that ends the wready cycle; reset drops it.
    mem_we = (state == WR_WAIT) && (cnt == '0) && !cur_fault && !rst;
  end

  ysyx_lsu_mem_responder_sram_1rw #(
    .WORDS  (MEM_WORDS),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .BYTES  (BYTES)
  ) u_sram_1rw (
    .clk     (clk),
    .rd_idx  (idx),
    .rd_data (rd_word),
    .we      (mem_we),
    .wr_idx  (idx),
    .wr_data (wr_word),
    .wr_be   (wr_be)
  );

  // Request FSM, latency counter, captured request and registered responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
      lsu_rvalid   <= 1'b0;
      lsu_wready   <= 1'b0;
      access_fault <= 1'b0;
      lsu_rdata    <= '0;
    end else begin
      lsu_rvalid   <= rd_fire;
      lsu_wready   <= wr_fire;
      access_fault <= (rd_fire | wr_fire) & cur_fault;
      if (rd_fire) lsu_rdata <= cur_fault ? '0 : (rd_shift & rd_mask);

      case (state)
        IDLE: begin
          if (wr_req) begin
            addr_q  <= lsu_awaddr;
            wdata_q <= lsu_wdata;
            strb_q  <= lsu_wstrb;
            cnt     <= CNT_W'(WR_LAT - 1);
            state   <= WR_WAIT;
          end else if (lsu_arvalid) begin
            addr_q  <= lsu_araddr;
            strb_q  <= lsu_rstrb;
            cnt     <= CNT_W'(RD_LAT - 1);
            state   <= RD_WAIT;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (cnt == '0) state <= TURN;
          else           cnt   <= cnt - CNT_W'(1);
        end
        TURN:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_lsu_mem_responder.sv
// Scoreboard bench for the LSU memory responder.
`timescale 1ns/1ps
module tb_ysyx_lsu_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic        arvalid, awvalid, wvalid, rvalid, wready, fault;
  logic [7:0]  rstrb, wstrb;

  logic [31:0] a3_araddr, r3_rdata;
  logic        a3_arvalid, r3_rvalid, r3_wready, r3_fault;
  logic [7:0]  a3_rstrb;

  typedef struct {
    bit          is_wr;
    logic [31:0] data;
    bit          fault;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ysyx_lsu_mem_responder dut (
    .clk          (clk),
    .rst          (rst),
    .lsu_araddr   (araddr),
    .lsu_arvalid  (arvalid),
    .lsu_rstrb    (rstrb),
    .lsu_rdata    (rdata),
    .lsu_rvalid   (rvalid),
    .lsu_awaddr   (awaddr),
    .lsu_awvalid  (awvalid),
    .lsu_wdata    (wdata),
    .lsu_wstrb    (wstrb),
    .lsu_wvalid   (wvalid),
    .lsu_wready   (wready),
    .access_fault (fault)
  );

  ysyx_lsu_mem_responder #(.RD_LAT(3)) dut3 (
    .clk          (clk),
    .rst          (rst),
    .lsu_araddr   (a3_araddr),
    .lsu_arvalid  (a3_arvalid),
    .lsu_rstrb    (a3_rstrb),
    .lsu_rdata    (r3_rdata),
    .lsu_rvalid   (r3_rvalid),
    .lsu_awaddr   (32'h0),
    .lsu_awvalid  (1'b0),
    .lsu_wdata    (32'h0),
    .lsu_wstrb    (8'h0),
    .lsu_wvalid   (1'b0),
    .lsu_wready   (r3_wready),
    .access_fault (r3_fault)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s: got %08h want %08h (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input bit is_wr, input logic [31:0] data, input bit flt, input int due);
    exp_t x;
    x.is_wr = is_wr;
    x.data  = data;
    x.fault = flt;
    x.due   = due;
    sb.push_back(x);
  endtask

  task automatic wait_resp(input bit is_wr);
    int n    = 0;
    bit seen = 1'b0;
    while (!seen && n < 20) begin
      tick(1);
      n++;
      seen = is_wr ? wready : rvalid;
    end
    chk(is_wr ? "wr_seen" : "rd_seen", 32'(seen), 32'd1);
  endtask

  task automatic st(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] strb,
                    input bit flt);
    push_exp(1'b1, data, flt, cyc + LAT);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    wait_resp(1'b1);
    awvalid = 1'b0; wvalid = 1'b0;
    tick(2);
  endtask

  task automatic ld(input logic [31:0] addr, input logic [7:0] strb, input logic [31:0] want,
                    input bit flt);
    push_exp(1'b0, want, flt, cyc + LAT);
    araddr = addr; rstrb = strb; arvalid = 1'b1;
    wait_resp(1'b0);
    arvalid = 1'b0;
    tick(2);
  endtask

  // Monitor: every response pops the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (rvalid || wready)) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("wready", 32'(wready), 32'(e.is_wr));
        chk("rvalid", 32'(rvalid), 32'(!e.is_wr));
        if (!e.is_wr) chk("rdata", rdata, e.data);
        chk("fault", 32'(fault), 32'(e.fault));
        chk("resp_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] pat;
    int          c;
    araddr = '0; arvalid = 1'b0; rstrb = 8'h0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = 8'h0; wvalid = 1'b0;
    a3_araddr = 32'h8000_0000; a3_arvalid = 1'b0; a3_rstrb = 8'h0f;
    rst = 1'b1;
    tick(3);
    @(negedge clk);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(1);

    // Byte/half extraction from a preloaded word
    st(32'h8000_0010, 32'h8899_aabb, 8'h0f, 1'b0);
    ld(32'h8000_0012, 8'h01, 32'h0000_0099, 1'b0);
    ld(32'h8000_0012, 8'h03, 32'h0000_8899, 1'b0);
    ld(32'h8000_0013, 8'h01, 32'h0000_0088, 1'b0);

    // Partial store merges into an existing word
    st(32'h8000_0020, 32'h1234_5678, 8'h0f, 1'b0);
    st(32'h8000_0022, 32'h0000_abcd, 8'h03, 1'b0);
    ld(32'h8000_0020, 8'h0f, 32'habcd_5678, 1'b0);
    ld(32'h8000_0021, 8'h03, 32'h0000_cd56, 1'b0);

    // Simultaneous store and load: store first, load after TURN sees new data
    c = cyc;
    push_exp(1'b1, 32'hcafe_f00d, 1'b0, c + 2);
    push_exp(1'b0, 32'hcafe_f00d, 1'b0, c + 6);
    awaddr = 32'h8000_0040; wdata = 32'hcafe_f00d; wstrb = 8'h0f; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h8000_0040; rstrb = 8'h0f; arvalid = 1'b1;
    wait_resp(1'b1);
    awvalid = 1'b0; wvalid = 1'b0;
    wait_resp(1'b0);
    arvalid = 1'b0;
    tick(2);

    // Faults: misalignment, range, bad strobe; faulted stores write nothing
    st(32'h8000_0000, 32'h0bad_f00d, 8'h0f, 1'b0);
    ld(32'h8000_0002, 8'h0f, 32'h0, 1'b1);
    ld(32'h0000_1000, 8'h0f, 32'h0, 1'b1);
    st(32'h0000_1000, 32'h5555_aaaa, 8'h0f, 1'b1);
    ld(32'h8000_0000, 8'h0f, 32'h0bad_f00d, 1'b0);
    st(32'h8000_0013, 32'h0000_ffff, 8'h03, 1'b1);
    ld(32'h8000_0011, 8'h07, 32'h0, 1'b1);
    ld(32'h8000_0010, 8'h0f, 32'h8899_aabb, 1'b0);
    st(32'h8000_0ffc, 32'h7777_8888, 8'h0f, 1'b0);
    ld(32'h8000_0ffe, 8'h03, 32'h0000_7777, 1'b0);
    ld(32'h8000_1000, 8'h01, 32'h0, 1'b1);
    ld(32'h7fff_ffff, 8'h01, 32'h0, 1'b1);

    // Reset the cycle after a store is accepted: dropped, FSM idle right after
    st(32'h8000_0030, 32'h1111_2222, 8'h0f, 1'b0);
    awaddr = 32'h8000_0030; wdata = 32'hdead_beef; wstrb = 8'h0f; awvalid = 1'b1; wvalid = 1'b1;
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    ld(32'h8000_0030, 8'h0f, 32'h1111_2222, 1'b0);

    // RD_LAT=3 with arvalid held 10 cycles: pulses at T+3 and T+8 only
    pat = '0;
    a3_arvalid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      pat[k] = r3_rvalid;
      if (k == 9) begin
        @(posedge clk); #1;
        a3_arvalid = 1'b0;
      end
    end
    chk("lat3_pulses", 32'(pat), 32'h0000_0108);

    tick(4);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ysyx_lsu_mem_responder.md
# ysyx_lsu_mem_responder

Bus-side responder for the LSU load/store request interface: it accepts one load or store at a time, models a word-organised data SRAM with a programmable access latency, and answers with a single-cycle `lsu_rvalid` or `lsu_wready` pulse. It sits between the LSU bus ports and the simulated memory and serves as the reference data memory in NPC simulation. It also provides the latency behaviour that exercises the LSU's L1D fill and invalidate paths.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (one word)
- `MEM_BASE`, 32'h8000_0000, byte address of word 0
- `MEM_WORDS`, 1024, memory depth in words (power of two)
- `RD_LAT`, 2, cycles from read acceptance to `lsu_rvalid` (>=1)
- `WR_LAT`, 2, cycles from write acceptance to `lsu_wready` (>=1)

- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: reset, synchronous, active-high
- `lsu_araddr` in ADDR_W: load byte address
- `lsu_arvalid` in 1: load request, level-held until `lsu_rvalid`
- `lsu_rstrb` in 8: load size: 8'h1 byte, 8'h3 half, 8'hf word
- `lsu_rdata` out DATA_W: load data, right-aligned, valid only with `lsu_rvalid`
- `lsu_rvalid` out 1: one-cycle load response
- `lsu_awaddr` in ADDR_W: store byte address
- `lsu_awvalid` in 1: store address valid, level-held until `lsu_wready`
- `lsu_wdata` in DATA_W: store data, right-aligned (byte 0 = bits 7:0)
- `lsu_wstrb` in 8: store size, same encoding as `lsu_rstrb`
- `lsu_wvalid` in 1: store data valid; a store is accepted only when `lsu_awvalid & lsu_wvalid`
- `lsu_wready` out 1: one-cycle store completion
- `access_fault` out 1: pulses with `lsu_rvalid` or `lsu_wready` when the access faulted

## Operation
- FSM states: IDLE, RD_WAIT, WR_WAIT, TURN.
- IDLE:
  - A store request (`lsu_awvalid & lsu_wvalid`) → capture address, data and strobe; load the counter with WR_LAT-1; go to WR_WAIT.
  - Otherwise `lsu_arvalid` → capture address and strobe; load the counter with RD_LAT-1; go to RD_WAIT.
  - Store wins when both requests are present; the load is served afterwards because `lsu_arvalid` is held.
- RD_WAIT, counter nonzero: decrement.
- RD_WAIT, counter zero:
  - Assert `lsu_rvalid` for one cycle with `lsu_rdata` = memory word >> (8 × addr[1:0]).
  - Mask the result to the strobe size: bits above the access size read 0. The LSU does sign extension.
  - Go to TURN.
- WR_WAIT, counter zero:
  - Commit the store: shift data and strobe left by addr[1:0] and write only the strobed bytes.
  - Assert `lsu_wready` for one cycle; go to TURN.
- TURN: one cycle that ignores all requests, so a still-asserted valid is not re-accepted; then go to IDLE.
- Captured request fields are frozen after acceptance; input changes while in a WAIT state are ignored.
- Fault conditions, in either direction:
  - the address is outside [MEM_BASE, MEM_BASE + 4·MEM_WORDS);
  - the access crosses a word boundary (half at offset 3, word at offset ≠ 0);
  - the strobe is not one of 1, 3, f.
- Fault response:
  - the response still pulses at normal latency, with `access_fault` = 1;
  - a faulted load returns `lsu_rdata` = 0;
  - a faulted store writes nothing.
- Word index is (addr − MEM_BASE)[log2(MEM_WORDS)+1:2].

## Timing
- Acceptance in cycle T (IDLE, request sampled):
  - `lsu_rvalid` is high in cycle T+RD_LAT;
  - `lsu_wready` is high in cycle T+WR_LAT.
- The earliest next acceptance is T+LAT+2, which gives a throughput of one access per LAT+2 cycles.
- A store becomes visible to a load accepted in any later cycle; the memory is written on the `lsu_wready` edge.
- Reset values:
  - state IDLE, counter 0;
  - `lsu_rvalid`, `lsu_wready` and `access_fault` = 0;
  - `lsu_rdata` = 0.
- Memory contents are not reset.
- Reset mid-operation drops the transaction: no response is issued and no memory write is committed.
- All outputs are registered; there are no combinational input→output paths.

## Structure
- Shared package (`ysyx_macro.v` defines):
  - strobe encodings `ysyx_STRB_B`/`H`/`W` = 1/3/f;
  - the state encodings;
  - MEM_BASE default.
- One natural sub-module: `ysyx_sram_1rw` holds the word array with byte-write-enable, one read and one write port. It has a synchronous write, and its read is registered into the response.
- Top level holds the FSM, latency counter, alignment and shift logic, and fault checks.

## Test plan
- Preload word 0x8000_0010 = 32'h8899_aabb; load, strobe 8'h1, addr 0x8000_0012 → `lsu_rvalid` at T+2, `lsu_rdata` = 32'h0000_0099, no fault.
- Store word 32'h1234_5678 to 0x8000_0020, then store half 32'h0000_abcd, strobe 8'h3, to 0x8000_0022 → `lsu_wready` at T+2 for each; a load word from 0x8000_0020 then returns 32'habcd_5678.
- `lsu_arvalid` and `lsu_awvalid & lsu_wvalid` asserted together in IDLE, both held → `lsu_wready` first, one TURN cycle, then `lsu_rvalid`, with the load returning the freshly stored data.
- Load word from 0x8000_0002 and load from 0x0000_1000 → `lsu_rvalid` and `access_fault` both 1, `lsu_rdata` = 0; a store to 0x0000_1000 leaves the memory unchanged.
- Hold `lsu_arvalid` for 10 cycles with RD_LAT=3 → `lsu_rvalid` pulses at T+3 and T+8 only, never on consecutive cycles.
- Assert `rst` in the cycle after a store is accepted → no `lsu_wready`, target word unchanged, FSM in IDLE on the following cycle.
